// File: rtl/key_pkg.sv
// Shared types and helpers for the key event decoder.
package key_pkg;

  // Per-key tracking state.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } key_state_e;

  // Clock cycles per 1 ms tick, clamped to at least one cycle.
  function automatic int unsigned tick_div(input int unsigned clk_speed);
    return ((clk_speed / 1000) == 0) ? 1 : (clk_speed / 1000);
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Free-running 1 ms strobe generator shared by all key channels.
module ms_tick
  import key_pkg::*;
#(
  parameter int unsigned ClkSpeed = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int unsigned Div  = tick_div(ClkSpeed);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] r_cnt;
  logic            r_tick;

  // Divide the clock down and emit a one-cycle strobe at each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CntW'(Div - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CntW'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/key_event.sv
// Turns debounced key levels into press/release/long/repeat pulses and a held level.
module key_event
  import key_pkg::*;
#(
  parameter int unsigned Size     = 1,
  parameter int unsigned ClkSpeed = 10_000_000,
  parameter int unsigned LongMs   = 1000,
  parameter int unsigned RepeatMs = 200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [Size-1:0] i_key,
  output logic [Size-1:0] o_press,
  output logic [Size-1:0] o_release,
  output logic [Size-1:0] o_long,
  output logic [Size-1:0] o_repeat,
  output logic [Size-1:0] o_held
);

  localparam int unsigned CntW = $clog2(LongMs + 1);
  localparam int unsigned IncW = CntW + 1;

  logic            w_tick;
  logic [Size-1:0] r_iq;
  logic [Size-1:0] w_rise;
  logic [Size-1:0] w_fall;

  ms_tick #(.ClkSpeed(ClkSpeed)) u_ms_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  // Previous key sample; resets high so a key held through reset is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_iq <= '1;
    else        r_iq <= i_key;
  end

  assign w_rise = i_key & ~r_iq;
  assign w_fall = ~i_key & r_iq;

  for (genvar g = 0; g < Size; g++) begin : g_key
    key_state_e      r_state;
    key_state_e      w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic [IncW-1:0] w_inc;
    logic            w_press, w_release, w_long, w_repeat;
    logic            r_press, r_release, r_long, r_repeat, r_held;

    assign w_inc = {1'b0, r_cnt} + IncW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
    end

    // Next-state logic; a fall always takes priority over a threshold tick.
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        ST_IDLE: begin
          if (w_rise[g]) w_state_nxt = ST_PRESSED;
        end
        ST_PRESSED: begin
          if (w_fall[g])                              w_state_nxt = ST_IDLE;
          else if (w_tick && (w_inc == IncW'(LongMs))) w_state_nxt = ST_LONG;
        end
        ST_LONG: begin
          if (w_fall[g]) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // Event and hold-counter logic.
    always_comb begin
      w_press   = 1'b0;
      w_release = 1'b0;
      w_long    = 1'b0;
      w_repeat  = 1'b0;
      w_cnt_nxt = r_cnt;
      case (r_state)
        ST_IDLE: begin
          if (w_rise[g]) begin
            w_press   = 1'b1;
            w_cnt_nxt = '0;
          end
        end
        ST_PRESSED: begin
          if (w_fall[g]) begin
            w_release = 1'b1;
          end else if (w_tick) begin
            if (w_inc == IncW'(LongMs)) begin
              w_long    = 1'b1;
              w_cnt_nxt = '0;
            end else begin
              w_cnt_nxt = w_inc[CntW-1:0];
            end
          end
        end
        ST_LONG: begin
          if (w_fall[g]) begin
            w_release = 1'b1;
          end else if (w_tick && (RepeatMs != 0)) begin
            if (w_inc == IncW'(RepeatMs)) begin
              w_repeat  = 1'b1;
              w_cnt_nxt = '0;
            end else begin
              w_cnt_nxt = w_inc[CntW-1:0];
            end
          end
        end
        default: ;
      endcase
    end

    // Registered outputs and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt     <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
        r_held    <= 1'b0;
      end else begin
        r_cnt     <= w_cnt_nxt;
        r_press   <= w_press;
        r_release <= w_release;
        r_long    <= w_long;
        r_repeat  <= w_repeat;
        r_held    <= (w_state_nxt != ST_IDLE);
      end
    end

    assign o_press[g]   = r_press;
    assign o_release[g] = r_release;
    assign o_long[g]    = r_long;
    assign o_repeat[g]  = r_repeat;
    assign o_held[g]    = r_held;
  end

endmodule

// File: tb/tb_key_event.sv
// Randomized scoreboard bench for key_event: one instance with repeat, one without.
module tb_key_event;

  localparam int unsigned NK        = 2;
  localparam int unsigned CLK_SPEED = 10_000;
  localparam int unsigned LONG_MS   = 5;
  localparam int unsigned REP_MS    = 2;
  localparam int          DIV       = CLK_SPEED / 1000;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] i_key;

  logic [NK-1:0] a_press, a_rel, a_long, a_rep, a_held;
  logic [NK-1:0] b_press, b_rel, b_long, b_rep, b_held;

  key_event #(.Size(NK), .ClkSpeed(CLK_SPEED), .LongMs(LONG_MS), .RepeatMs(REP_MS)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_key(i_key),
    .o_press(a_press), .o_release(a_rel), .o_long(a_long), .o_repeat(a_rep), .o_held(a_held)
  );

  key_event #(.Size(NK), .ClkSpeed(CLK_SPEED), .LongMs(LONG_MS), .RepeatMs(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_key(i_key),
    .o_press(b_press), .o_release(b_rel), .o_long(b_long), .o_repeat(b_rep), .o_held(b_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs per edge: {inst A 10 bits, inst B 10 bits}.
  logic [19:0] sb_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model state: edges since reset, previous sample, press tracking and ticks held.
  int          edge_k = 0;
  logic [1:0]  m_prev = 2'b11;
  bit          m_trk   [2][2];
  int          m_ticks [2][2];

  // Reference model: ticks land on edges 1+m*DIV after reset; events follow from tick counts since press.
  always @(posedge clk) begin : model
    logic [1:0]  ep, er, el, erp, eh;
    logic [19:0] e;
    bit          tk;
    int          rp;
    e = '0;
    if (!rst_n) begin
      edge_k = 0;
      m_prev = 2'b11;
      for (int r = 0; r < 2; r++)
        for (int j = 0; j < 2; j++) begin
          m_trk[r][j]   = 1'b0;
          m_ticks[r][j] = 0;
        end
    end else begin
      edge_k = edge_k + 1;
      tk = (edge_k > 1) && (((edge_k - 1) % DIV) == 0);
      for (int r = 0; r < 2; r++) begin
        rp = (r == 0) ? int'(REP_MS) : 0;
        ep = '0; er = '0; el = '0; erp = '0; eh = '0;
        for (int j = 0; j < 2; j++) begin
          if (!m_trk[r][j] && i_key[j] && !m_prev[j]) begin
            m_trk[r][j]   = 1'b1;
            m_ticks[r][j] = 0;
            ep[j] = 1'b1;
          end else if (m_trk[r][j] && !i_key[j] && m_prev[j]) begin
            m_trk[r][j] = 1'b0;
            er[j] = 1'b1;
          end else if (m_trk[r][j] && tk) begin
            m_ticks[r][j] = m_ticks[r][j] + 1;
            if (m_ticks[r][j] == int'(LONG_MS))
              el[j] = 1'b1;
            else if (m_ticks[r][j] > int'(LONG_MS) && rp != 0 &&
                     ((m_ticks[r][j] - int'(LONG_MS)) % rp) == 0)
              erp[j] = 1'b1;
          end
          eh[j] = m_trk[r][j];
        end
        if (r == 0) e[19:10] = {ep, er, el, erp, eh};
        else        e[9:0]   = {ep, er, el, erp, eh};
      end
      m_prev = i_key;
    end
    sb_q.push_back(e);
  end

  // Monitor: on each falling edge pop the expected outputs and compare both instances.
  always @(negedge clk) begin : monitor
    logic [19:0] exp_v;
    logic [9:0]  act_a, act_b;
    act_a = {a_press, a_rel, a_long, a_rep, a_held};
    act_b = {b_press, b_rel, b_long, b_rep, b_held};
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: no expected entry at time %0t", $time);
    end else begin
      exp_v = sb_q.pop_front();
      if (!rst_n) exp_v = '0;
      total++;
      if (act_a !== exp_v[19:10]) begin
        bad++;
        $display("FAIL out_rep%0d edge=%0d got=%b want=%b (press,rel,long,rep,held)",
                 REP_MS, edge_k, act_a, exp_v[19:10]);
      end
      total++;
      if (act_b !== exp_v[9:0]) begin
        bad++;
        $display("FAIL out_rep0 edge=%0d got=%b want=%b (press,rel,long,rep,held)",
                 edge_k, act_b, exp_v[9:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stimulus: directed scenarios followed by random key patterns.
  initial begin : stim
    int p, t1, t5;
    rst_n = 1'b0;
    i_key = '0;
    cyc(3);
    rst_n = 1'b1;

    // Short press on key 0.
    cyc(19);
    i_key[0] = 1'b1; cyc(15);
    i_key[0] = 1'b0; cyc(10);

    // Long hold on key 0 with key 1 pressed during LONG.
    i_key[0] = 1'b1; cyc(70);
    i_key[1] = 1'b1; cyc(30);
    i_key[1] = 1'b0; cyc(20);
    i_key[0] = 1'b0; cyc(15);

    // Release landing on the tick that would fire long.
    p  = edge_k + 1;
    i_key[0] = 1'b1;
    t1 = 1 + ((p - 1) / DIV + 1) * DIV;
    t5 = t1 + (int'(LONG_MS) - 1) * DIV;
    while (edge_k < t5 - 1) cyc(1);
    i_key[0] = 1'b0; cyc(15);

    // Reset mid-hold, key held through reset, then a normal press.
    i_key[0] = 1'b1; cyc(70);
    rst_n = 1'b0; cyc(3);
    rst_n = 1'b1; cyc(80);
    i_key[0] = 1'b0; cyc(10);
    i_key[0] = 1'b1; cyc(12);
    i_key[0] = 1'b0; cyc(10);

    // Random key levels on both channels.
    for (int it = 0; it < 30; it++) begin
      i_key = 2'($urandom_range(0, 3));
      cyc(int'($urandom_range(1, 70)));
    end
    i_key = '0;
    cyc(10);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_event.md
# key_event

Per-key event decoder placed downstream of the debounce stage. Takes clean, debounced key levels and turns each key into one-cycle event pulses: press, release, long-press and auto-repeat while held. Timing is in milliseconds, derived from the system clock via a shared 1 ms tick, so front-panel logic consumes events rather than raw levels.

## Interface
- `Size`, 1: number of keys (independent channels).
- `ClkSpeed`, 10_000_000: clock frequency in Hz; one tick every `ClkSpeed/1000` cycles.
- `LongMs`, 1000: hold time in ms before `long` fires; legal 2..65535.
- `RepeatMs`, 200: auto-repeat period in ms after `long`; 0 disables repeat; must be < `LongMs`.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `I`  in  `Size`  debounced key levels, 1 = pressed, synchronous to `clk`.
- `press`  out  `Size`  one-cycle pulse on press.
- `release`  out  `Size`  one-cycle pulse on release of a tracked press.
- `long`  out  `Size`  one-cycle pulse, once per press, after `LongMs`.
- `repeat`  out  `Size`  one-cycle pulse every `RepeatMs` after `long` while held.
- `held`  out  `Size`  level, 1 while the key is in PRESSED or LONG.

## Operation
- Reset: all outputs 0; every key FSM in IDLE; previous-sample register `i_q` = all ones; tick divider and hold counters = 0.
- Edges per key: rise = `I & ~i_q`, fall = `~I & i_q`; `i_q <= I` every cycle.
- FSM per key, states IDLE, PRESSED, LONG:
  - IDLE + rise -> PRESSED, `press` pulse, hold counter = 0.
  - PRESSED + fall -> IDLE, `release` pulse.
  - PRESSED + tick, counter+1 == `LongMs` -> LONG, `long` pulse, counter = 0.
  - LONG + tick, `RepeatMs`!=0, counter+1 == `RepeatMs` -> `repeat` pulse, counter = 0; stay in LONG.
  - LONG + fall -> IDLE, `release` pulse.
  - Fall in IDLE ignored (no pulse).
- Counter increments only on tick; width `$clog2(LongMs+1)`, never wraps past `LongMs`.
- Simultaneous fall and threshold tick in same cycle: fall wins; `release` only, no `long`/`repeat`.
- Keys fully independent; shared tick only.
- Key held across reset deassertion: `i_q` = 1 so no rise seen; no `press`/`long`/`repeat`; its later release is ignored; next press is normal.
- Reset asserted mid-operation: outputs clear immediately (async), no trailing pulses.

## Timing
- All outputs registered. `I` sampled 1 at edge n with `i_q`=0: `press` high from edge n to edge n+1. Same for `release`.
- Tick: free-running divider from reset, one-cycle strobe every `ClkSpeed/1000` cycles; press-to-`long` latency therefore in (`LongMs`-1, `LongMs`] ms, quantized to tick edges; subsequent repeats exactly `RepeatMs` ms apart.
- `held` rises with `press`, falls with `release`.
- No two of `press`/`long`/`repeat`/`release` on the same key in the same cycle.

## Structure
- Package `key_pkg`: FSM state enum (IDLE, PRESSED, LONG), tick-divisor constant function.
- Sub-module `ms_tick` (parameter `ClkSpeed`, ports `clk`, `rst_n`, `tick`): shared 1 ms strobe generator, instanced once.
- Per-key FSM + counter in a generate loop over `Size`.

## Test plan
Bench parameters: `ClkSpeed`=10_000 (tick every 10 cycles), `LongMs`=5, `RepeatMs`=2, `Size`=2.
- Short press: `I[0]` 0->1 sampled at edge 20, back to 0 at edge 35 -> `press[0]`=1 edge 20-21 only, `release[0]`=1 edge 35-36, no `long`.
- Long hold: `I[0]` high 120 cycles -> exactly one `long[0]` 41-50 cycles after press, then `repeat[0]` every 20 cycles, `release[0]` on drop, `held[0]`=1 throughout.
- Race: release timed on the tick cycle reaching 5 -> `release` only, `long` stays 0.
- Independence: key 1 pressed during key 0 LONG -> key 1 `press` pulses, key 0 repeat cadence unchanged.
- Reset mid-hold: `rst_n` low 3 cycles with `I[0]`=1 -> outputs 0 immediately; after reset no `press`/`long`; later release gives no `release`; next press gives normal `press`.
- `RepeatMs`=0 rerun of long hold -> single `long`, zero `repeat`.
